// File: rtl/nv_nvdla_csc_credit_pkg.sv
// Shared definitions for the CSC side of the CACC->CSC accumulator credit loop.
// Holds the controller state encoding, the credit-size field width and the
// default accumulator depth that the CACC credit generator also uses.
package nv_nvdla_csc_credit_pkg;

  localparam int CSC_SIZE_W          = 3;
  localparam int CSC_CREDIT_INIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } csc_credit_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nv_nvdla_csc_accu_credit_ctrl_if.sv
// Signal bundle between the CSC sequencer / CACC credit return and the credit
// controller.
//   master : sequencer + CACC side (drives returns, layer_start, stripe requests)
//   slave  : credit controller (drives grant, count, drain pulse, error, state)
//
// Stripe handshake: a stripe transfers on a cycle where stripe_req_vld and
// stripe_req_rdy are both high. Once vld is raised, size and last stay stable
// until that transfer. rdy may be high without vld and never depends on vld.
// The credit return has no back-pressure: every cycle with accu2sc_credit_vld
// high is one return of accu2sc_credit_size credits.
interface nv_nvdla_csc_accu_credit_ctrl_if
  import nv_nvdla_csc_credit_pkg::*;
#(
  parameter int CREDIT_INIT = CSC_CREDIT_INIT_DEF,
  parameter int SIZE_W      = CSC_SIZE_W
) ();

  localparam int CNT_W = $clog2(CREDIT_INIT + 1);

  logic              accu2sc_credit_vld;
  logic [SIZE_W-1:0] accu2sc_credit_size;
  logic              layer_start;
  logic              stripe_req_vld;
  logic [SIZE_W-1:0] stripe_req_size;
  logic              stripe_req_last;
  logic              stripe_req_rdy;
  logic [CNT_W-1:0]  credit_cnt;
  logic              drain_done;
  logic              credit_err;
  csc_credit_state_e state_dbg;

  modport master (
    output accu2sc_credit_vld, accu2sc_credit_size, layer_start,
           stripe_req_vld, stripe_req_size, stripe_req_last,
    input  stripe_req_rdy, credit_cnt, drain_done, credit_err, state_dbg
  );

  modport slave (
    input  accu2sc_credit_vld, accu2sc_credit_size, layer_start,
           stripe_req_vld, stripe_req_size, stripe_req_last,
    output stripe_req_rdy, credit_cnt, drain_done, credit_err, state_dbg
  );

endinterface

// File: rtl/nv_nvdla_csc_credit_ret_pipe.sv
// Register stage for the credit return coming from CACC. Kept separate so it
// can be retimed or deepened when the CACC->CSC route is long.
//   clk, rst          : clock, synchronous active-high reset (clears the stage)
//   in_vld, in_size   : raw credit return from CACC
//   ret_vld, ret_size : the same return, one edge later
module nv_nvdla_csc_credit_ret_pipe
  import nv_nvdla_csc_credit_pkg::*;
#(
  parameter int SIZE_W = CSC_SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [SIZE_W-1:0] in_size,
  output logic              ret_vld,
  output logic [SIZE_W-1:0] ret_size
);

  logic              ret_vld_q,  ret_vld_d;
  logic [SIZE_W-1:0] ret_size_q, ret_size_d;

  always_comb begin
    ret_vld_d  = in_vld;
    ret_size_d = in_size;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_vld_q  <= 1'b0;
      ret_size_q <= '0;
    end else begin
      ret_vld_q  <= ret_vld_d;
      ret_size_q <= ret_size_d;
    end
  end

  assign ret_vld  = ret_vld_q;
  assign ret_size = ret_size_q;

endmodule

// File: rtl/nv_nvdla_csc_accu_credit_ctrl.sv
// CSC-side accumulator credit controller.
// Tracks free accumulator-buffer entries for the current layer, grants stripe
// issue only when enough credits are free, detects the end-of-layer drain
// (every credit back) and raises a sticky error on protocol violations.
//   nvdla_core_clk : clock
//   nvdla_core_rst : synchronous active-high reset; aborts any layer in flight
//   bus (slave)    : credit return in, layer_start, stripe request/grant,
//                    credit_cnt, drain_done pulse, credit_err, state_dbg
module nv_nvdla_csc_accu_credit_ctrl
  import nv_nvdla_csc_credit_pkg::*;
#(
  parameter int CREDIT_INIT = CSC_CREDIT_INIT_DEF,
  parameter int SIZE_W      = CSC_SIZE_W
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  nv_nvdla_csc_accu_credit_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CREDIT_INIT + 1);
  // Arithmetic width: one bit above the wider of count and size, so that
  // count + largest return never wraps even for a tiny CREDIT_INIT.
  localparam int AW = max_w(CNT_W, SIZE_W) + 1;
  localparam logic [AW-1:0]    INIT_A = AW'(CREDIT_INIT);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(CREDIT_INIT);

  csc_credit_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain_done_q, drain_done_d;
  logic              err_q, err_d;

  logic              ret_vld;
  logic [SIZE_W-1:0] ret_size;
  logic              stripe_rdy;
  logic              fire;
  logic [AW-1:0]     ret_amt, use_amt, nxt_raw, nxt_cnt;
  logic              ovf;

  nv_nvdla_csc_credit_ret_pipe #(.SIZE_W(SIZE_W)) u_ret_pipe (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .in_vld   (bus.accu2sc_credit_vld),
    .in_size  (bus.accu2sc_credit_size),
    .ret_vld  (ret_vld),
    .ret_size (ret_size)
  );

  // Grant looks only at the registered count; a return sitting in the
  // pipe stage is not yet spendable.
  always_comb begin
    stripe_rdy = (state_q == ST_ACTIVE) &&
                 (AW'(cnt_q) >= AW'(bus.stripe_req_size));
  end

  assign fire = bus.stripe_req_vld & stripe_rdy;

  // Next count: return and consume net out in one cycle; anything above
  // the buffer depth is clamped and reported.
  always_comb begin
    ret_amt = ret_vld ? AW'(ret_size) : '0;
    use_amt = fire ? AW'(bus.stripe_req_size) : '0;
    nxt_raw = AW'(cnt_q) + ret_amt - use_amt;
    ovf     = (nxt_raw > INIT_A);
    nxt_cnt = ovf ? INIT_A : nxt_raw;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_done_d = 1'b0;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        // No layer owns the buffer, so a return here is spurious.
        if (ret_vld) err_d = 1'b1;
        if (bus.layer_start) begin
          state_d = ST_ACTIVE;
          cnt_d   = INIT_C;
        end
      end
      ST_ACTIVE: begin
        cnt_d = nxt_cnt[CNT_W-1:0];
        if (ovf || bus.layer_start) err_d = 1'b1;
        if (fire && bus.stripe_req_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_d = nxt_cnt[CNT_W-1:0];
        if (ovf || bus.layer_start) err_d = 1'b1;
        if (nxt_cnt == INIT_A) begin
          state_d      = ST_IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.stripe_req_rdy = stripe_rdy;
  assign bus.credit_cnt     = cnt_q;
  assign bus.drain_done     = drain_done_q;
  assign bus.credit_err     = err_q;
  assign bus.state_dbg      = state_q;

endmodule
